// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, error codes, FSM states and settle-time lookup for alu_rr_sequencer
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_MOD = 4'b0001;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DZ   = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Latencies are module parameters, so the caller passes them in.
  function automatic int op_lat(input logic [3:0] op, input int add_lat,
                                input int mul_lat, input int div_lat);
    int lat;
    case (op)
      OP_ADD, OP_SUB: lat = add_lat;
      OP_MUL:         lat = mul_lat;
      OP_DIV, OP_MOD: lat = div_lat;
      default:        lat = 0;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter; on contention the input not granted last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_id = gnt[1];

endmodule

// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - shares one external ALU between two requesters, one op in flight,
// op-dependent settle wait and a valid/ready response tagged with the requester id
module alu_rr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_r,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  state_t      r_state;
  logic        r_rr_last;
  logic [3:0]  r_cnt;
  logic        r_id;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [3:0]  r_alu_op;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_r;
  logic [1:0]  r_rsp_err;

  logic [1:0]  w_gnt;
  logic        w_gnt_id;
  logic        w_arb_en;
  logic        w_xfer;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [3:0]  w_op;
  logic [3:0]  w_cnt_init;
  logic [1:0]  w_cap_err;

  // Ready is held low while reset is asserted, even though the state reads IDLE.
  assign w_arb_en = (r_state == ST_IDLE) && rst_n;

  rr_arb2 u_arb (
    .req    ({req1_valid, req0_valid}),
    .last   (r_rr_last),
    .enable (w_arb_en),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];
  assign w_xfer     = |w_gnt;
  assign w_a        = w_gnt_id ? req1_a  : req0_a;
  assign w_b        = w_gnt_id ? req1_b  : req0_b;
  assign w_op       = w_gnt_id ? req1_op : req0_op;
  assign w_cnt_init = 4'(op_lat(w_op, ADD_LAT, MUL_LAT, DIV_LAT) - 1);

  always_comb begin
    w_cap_err = ERR_NONE;
    if ((r_alu_op == OP_ADD || r_alu_op == OP_SUB) && alu_ovf)
      w_cap_err = ERR_OVF;
    else if ((r_alu_op == OP_DIV || r_alu_op == OP_MOD) && r_alu_b == 16'd0)
      w_cap_err = ERR_DZ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_last   <= 1'b1;
      r_cnt       <= 4'd0;
      r_id        <= 1'b0;
      r_alu_a     <= 16'd0;
      r_alu_b     <= 16'd0;
      r_alu_op    <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_r     <= 32'd0;
      r_rsp_err   <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_rr_last <= w_gnt_id;
            r_id      <= w_gnt_id;
            if (op_legal(w_op)) begin
              r_alu_a  <= w_a;
              r_alu_b  <= w_b;
              r_alu_op <= w_op;
              r_cnt    <= w_cnt_init;
              r_state  <= ST_WAIT;
            end else begin
              // Illegal ops never reach the ALU; the previous operands stay on alu_*.
              r_rsp_id    <= w_gnt_id;
              r_rsp_r     <= 32'd0;
              r_rsp_err   <= ERR_ILL;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_id    <= r_id;
            r_rsp_r     <= alu_r;
            r_rsp_err   <= w_cap_err;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_r     = r_rsp_r;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - randomized self-checking bench for alu_rr_sequencer with an ALU stand-in
module tb_alu_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_ovf;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
  logic [31:0] rsp_r;
  logic [1:0]  rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_rr_sequencer #(.ADD_LAT(1), .MUL_LAT(2), .DIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .busy(busy)
  );

  // ALU stand-in: signed add/sub with overflow, unsigned mul/div/mod, all-ones on divide by zero.
  function automatic logic [32:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int s;
    logic [31:0] r;
    logic o;
    r = 32'd0; o = 1'b0;
    case (op)
      4'b0000: begin s = int'($signed(a)) + int'($signed(b)); r = 32'(s); o = (s > 32767) || (s < -32768); end
      4'b1000: begin s = int'($signed(a)) - int'($signed(b)); r = 32'(s); o = (s > 32767) || (s < -32768); end
      4'b0100: r = {16'd0, a} * {16'd0, b};
      4'b0010: r = (b == 16'd0) ? 32'hFFFF_FFFF : {16'd0, a / b};
      4'b0001: r = (b == 16'd0) ? 32'hFFFF_FFFF : {16'd0, a % b};
      default: r = 32'd0;
    endcase
    return {o, r};
  endfunction

  always_comb {alu_ovf, alu_r} = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return op == 4'b0000 || op == 4'b1000 || op == 4'b0100 || op == 4'b0010 || op == 4'b0001;
  endfunction

  // Reference model state: pending requests, round-robin memory, operands last sent to the ALU.
  bit          p_v[2];
  logic [15:0] p_a[2], p_b[2];
  logic [3:0]  p_op[2];
  int          m_last = 1;
  logic [15:0] m_a = '0, m_b = '0;
  logic [3:0]  m_op = '0;

  task automatic drive_reqs();
    req0_valid = p_v[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_op = p_op[0];
    req1_valid = p_v[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_op = p_op[1];
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    p_v[id] = 1'b1; p_a[id] = a; p_b[id] = b; p_op[id] = op;
  endtask

  // Called at a negedge with the DUT idle; runs one op through accept, settle, response and handshake.
  task automatic serve(input int hold);
    int w, lat, n;
    logic [31:0] er;
    logic [1:0]  ee;
    logic [32:0] f;
    drive_reqs();
    w = (p_v[0] && p_v[1]) ? (m_last == 1 ? 0 : 1) : (p_v[0] ? 0 : 1);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("ready0", req0_ready, w == 0);
    chk("ready1", req1_ready, w == 1);
    if (is_legal(p_op[w])) begin
      f   = alu_fn(p_a[w], p_b[w], p_op[w]);
      er  = f[31:0];
      lat = (p_op[w] == 4'b0100) ? 2 : ((p_op[w] == 4'b0010 || p_op[w] == 4'b0001) ? 4 : 1);
      if ((p_op[w] == 4'b0010 || p_op[w] == 4'b0001) && p_b[w] == 16'd0) ee = 2'b10;
      else if ((p_op[w] == 4'b0000 || p_op[w] == 4'b1000) && f[32])      ee = 2'b01;
      else                                                                ee = 2'b00;
      m_a = p_a[w]; m_b = p_b[w]; m_op = p_op[w];
    end else begin
      er = 32'd0; ee = 2'b11; lat = 0;
    end
    m_last = w;
    p_v[w] = 1'b0;
    @(negedge clk);
    drive_reqs();
    n = 1;
    while (!rsp_valid && n < 40) begin
      chk("wait_busy", busy, 1'b1);
      chk("wait_no_ready", {req1_ready, req0_ready}, 2'b00);
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat + 1);
    chk("rsp_id", rsp_id, w[0]);
    chk("rsp_r", rsp_r, er);
    chk("rsp_err", rsp_err, ee);
    chk("alu_ops", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rsp", {rsp_r[29:0], rsp_err}, {er[29:0], ee});
      chk("hold_id", rsp_id, w[0]);
      chk("hold_no_ready", {req1_ready, req0_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", {rsp_valid, busy}, 2'b00);
  endtask

  task automatic drain();
    while (p_v[0] || p_v[1]) serve(0);
  endtask

  initial begin
    int k;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    req1_valid = 1'b1;
    #1;
    chk("reset_outs", {alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready},
        '0);
    chk("reset_rsp_r", rsp_r, 32'd0);
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_req(0, 16'd9, 16'd6, 4'b0000);      serve(0);
    set_req(1, 16'd9, 16'd6, 4'b0100);      serve(0);
    set_req(0, 16'd9, 16'd0, 4'b0010);      serve(0);
    set_req(0, 16'h8000, 16'd1, 4'b1000);   serve(0);

    // Continuous contention: grants must alternate.
    set_req(0, 16'd1, 16'd2, 4'b0000);
    set_req(1, 16'd3, 16'd4, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      serve(0);
      if (!p_v[0]) set_req(0, 16'(i), 16'd7, 4'b0000);
      if (!p_v[1]) set_req(1, 16'(i), 16'd9, 4'b0000);
    end
    drain();

    set_req(1, 16'd300, 16'd7, 4'b0001);    serve(10);
    set_req(1, 16'd5, 16'd5, 4'b0111);      serve(2);

    // Reset during a divide's settle window.
    set_req(0, 16'd100, 16'd3, 4'b0010);
    drive_reqs();
    @(negedge clk);
    p_v[0] = 1'b0;
    set_req(1, 16'd1, 16'd1, 4'b0000);
    drive_reqs();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready},
        '0);
    chk("arst_rsp_r", rsp_r, 32'd0);
    p_v[1] = 1'b0;
    drive_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1; m_a = '0; m_b = '0; m_op = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {rsp_valid, busy}, 2'b00);
    end
    set_req(0, 16'd11, 16'd12, 4'b0000);
    set_req(1, 16'd13, 16'd14, 4'b0000);
    drain();

    // Randomized traffic: pending requests persist until granted.
    for (int it = 0; it < 80; it++) begin
      for (int id = 0; id < 2; id++) begin
        if (!p_v[id] && ($urandom_range(0, 1) == 1 || (id == 1 && !p_v[0]))) begin
          k = int'($urandom_range(0, 6));
          case (k)
            0: p_op[id] = 4'b0000;
            1: p_op[id] = 4'b1000;
            2: p_op[id] = 4'b0100;
            3: p_op[id] = 4'b0010;
            4: p_op[id] = 4'b0001;
            default: begin
              p_op[id] = 4'($urandom_range(0, 15));
              while (is_legal(p_op[id]) && k == 5) p_op[id] = 4'($urandom_range(0, 15));
            end
          endcase
          p_a[id] = 16'($urandom);
          p_b[id] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
          p_v[id] = 1'b1;
        end
      end
      serve(int'($urandom_range(0, 3)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
- Shares one combinational 16-bit ALU datapath (add/sub/mul/div/mod, 4-bit op_code, 32-bit result, overflow flag) between two requesters.
- Arbitrates round-robin, latches the winner's operands and opcode, and drives them to the ALU.
- Waits an op-dependent settle time, captures the result and error, and returns it over a valid/ready response channel tagged with the requester id.
- Sits between the requesters and the ALU, which it instantiates from outside.

Parameters:
- ADD_LAT, 1, settle cycles for add/sub (op 0000, 1000)
- MUL_LAT, 2, settle cycles for mul (op 0100)
- DIV_LAT, 4, settle cycles for div/mod (op 0010, 0001); every LAT ≥ 1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  16  requester 0 operand A
- req0_b  in  16  requester 0 operand B
- req0_op  in  4  requester 0 op_code
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same widths and meanings for requester 1
- alu_a  out  16  registered operand A to the ALU
- alu_b  out  16  registered operand B to the ALU
- alu_op  out  4  registered op_code to the ALU
- alu_r  in  32  ALU result
- alu_ovf  in  1  ALU add/sub overflow
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that issued the operation
- rsp_r  out  32  captured result
- rsp_err  out  2  00 none, 01 overflow, 10 divide-by-zero, 11 illegal op
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_last=1 (requester 0 wins first), cnt=0.
- Outputs on reset: alu_a/alu_b/alu_op=0, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_err=00, req*_ready=0.
- States: IDLE, WAIT, RESP.
- IDLE, arbitration:
  - reqN_ready is combinational and asserted only in IDLE, only to the grant winner.
  - Only one valid: that requester wins.
  - Both valid: the requester != rr_last wins.
- IDLE, on transfer (valid & ready):
  - Register a/b/op onto alu_*, record id, set rr_last=id.
  - Load cnt with the op's LAT-1, go to WAIT.
- Illegal op (any op outside the five legal codes):
  - Accept normally.
  - Do not change alu_* (previous values held).
  - Go directly to RESP with rsp_r=0 and rsp_err=11.
- WAIT:
  - alu_* stable; cnt decrements each cycle.
  - At cnt==0: capture rsp_r=alu_r and rsp_err, set rsp_valid=1, go to RESP.
  - Accept-to-rsp_valid latency is LAT+1 cycles.
- rsp_err at capture:
  - 01 if op in {0000, 1000} and alu_ovf.
  - 10 if op in {0010, 0001} and alu_b==0; rsp_r takes alu_r, which is 0xFFFFFFFF.
  - 00 otherwise.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - No new accept in the same cycle as the response handshake.
- Throughput: at most one operation in flight; requesters see ready=0 while busy.
- Requesters must hold valid and data until ready. Data changes while waiting are sampled at the accept edge.
- Reset mid-operation: the in-flight operation is dropped, no response is emitted, and rr_last returns to 1.
- Widths: operands pass through unmodified. No arithmetic is done in this block apart from the 4-bit cnt (wide enough for max LAT ≤ 16).

Decomposition:
- Package alu_seq_pkg holds:
  - op codes OP_ADD=0000, OP_SUB=1000, OP_MUL=0100, OP_DIV=0010, OP_MOD=0001
  - error codes ERR_NONE/ERR_OVF/ERR_DZ/ERR_ILL
  - state enum
  - function op_lat(op), returning the settle count
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], last, enable.
  - Outputs: gnt[1:0] (one-hot or zero), gnt_id.

Test Plan:
- Req0 a=9, b=6, op=0000 alone → req0_ready same cycle; rsp_valid 2 cycles later; rsp_r=15, rsp_id=0, rsp_err=00.
- Req1 a=9, b=6, op=0100 → rsp_valid exactly MUL_LAT+1=3 cycles after accept; rsp_r=54, rsp_id=1.
- Req0 a=9, b=0, op=0010 → rsp_err=10, rsp_r=0xFFFFFFFF after 5 cycles. Then op=1000, a=0x8000, b=1 → rsp_err=01.
- Both valid continuously with op=0000, rsp_ready=1 → grants alternate 0,1,0,1; neither requester is granted twice in a row; busy high between accepts.
- rsp_ready held 0 for 10 cycles → rsp_valid, rsp_r and rsp_id stay constant, no req*_ready asserted. op=0111 → immediate RESP with rsp_err=11, rsp_r=0, alu_* unchanged.
- Assert rst_n=0 during WAIT of a div → all outputs at reset values asynchronously; no response after release; next simultaneous request grants requester 0.
